// File: rtl/nios_setup_pb_ctrl.sv
// Avalon-MM pushbutton PIO: synchronizer, per-channel debounce,
// press-edge capture with W1C clear, masked level interrupt.
module nios_setup_pb_ctrl #(
  parameter int NCH            = 3,
  parameter int CNT_W          = 16,
  parameter int DEFAULT_PERIOD = 50000,
  parameter bit IDLE_LEVEL     = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [NCH-1:0]   in_port,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam logic [NCH-1:0]   IDLE_V  = {NCH{IDLE_LEVEL}};
  localparam logic [CNT_W-1:0] PER_RST = CNT_W'(DEFAULT_PERIOD);

  logic [NCH-1:0]   s1_q, s2_q;
  logic [NCH-1:0]   db_q, db_d;
  logic [NCH-1:0]   mask_q;
  logic [NCH-1:0]   edge_q, edge_d;
  logic [NCH-1:0]   edge_clr, press;
  logic [CNT_W-1:0] cnt_q [NCH];
  logic [CNT_W-1:0] cnt_d [NCH];
  logic [CNT_W-1:0] period_q, peff_m1;
  logic [31:0]      rdata_d;
  logic             wr_en;
  logic             unused_wd;

  assign wr_en     = chipselect & write;
  assign unused_wd = ^writedata;
  // PERIOD of 0 behaves as 1
  assign peff_m1 = (period_q == '0) ? '0
                 : period_q - CNT_W'(1);

  always_comb begin
    db_d = db_q;
    for (int i = 0; i < NCH; i++) begin
      cnt_d[i] = '0;
      if (s2_q[i] != db_q[i]) begin
        if (cnt_q[i] < peff_m1)
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        else
          db_d[i] = s2_q[i];
      end
    end
  end

  assign press    = (db_q ^ db_d) & ~(db_q ^ IDLE_V);
  assign edge_clr = (wr_en && address == 2'd2)
                  ? writedata[NCH-1:0] : '0;
  // a press wins over a same-cycle clear
  assign edge_d   = (edge_q & ~edge_clr) | press;

  always_comb begin
    rdata_d = '0;
    unique case (address)
      2'd0: rdata_d = 32'(db_q);
      2'd1: rdata_d = 32'(mask_q);
      2'd2: rdata_d = 32'(edge_q);
      2'd3: rdata_d = 32'(period_q);
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q     <= IDLE_V;
      s2_q     <= IDLE_V;
      db_q     <= IDLE_V;
      for (int i = 0; i < NCH; i++)
        cnt_q[i] <= '0;
      mask_q   <= '0;
      edge_q   <= '0;
      period_q <= PER_RST;
      readdata <= '0;
    end else begin
      s1_q     <= in_port;
      s2_q     <= s1_q;
      db_q     <= db_d;
      for (int i = 0; i < NCH; i++)
        cnt_q[i] <= cnt_d[i];
      edge_q   <= edge_d;
      readdata <= rdata_d;
      if (wr_en && address == 2'd1)
        mask_q <= writedata[NCH-1:0];
      if (wr_en && address == 2'd3)
        period_q <= writedata[CNT_W-1:0];
    end
  end

  assign irq = |(edge_q & mask_q);

endmodule

// File: doc/nios_setup_pb_ctrl.md
NIOS_SETUP_PB_CTRL -- requirements
Module: nios_setup_pb_ctrl

Interface
REQ-001 SHALL provide parameter NCH, default 3: number of pushbutton channels.
REQ-002 SHALL provide parameter CNT_W, default 16: debounce counter and period register width.
REQ-003 SHALL provide parameter DEFAULT_PERIOD, default 50000: reset value of PERIOD (1 ms at 50 MHz).
REQ-004 SHALL provide parameter IDLE_LEVEL, default 1: released-button input level (buttons active-low).
REQ-005 SHALL have port clk, input, 1 bit: single clock; all state on rising edge.
REQ-006 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port in_port, input, NCH bits: raw asynchronous button inputs.
REQ-008 SHALL have port address, input, 2 bits: Avalon-MM word address.
REQ-009 SHALL have port chipselect, input, 1 bit: slave select.
REQ-010 SHALL have port write, input, 1 bit: write strobe, qualified by chipselect.
REQ-011 SHALL have port writedata, input, 32 bits: write data.
REQ-012 SHALL have port readdata, output, 32 bits: registered read data.
REQ-013 SHALL have port irq, output, 1 bit: level interrupt to the Nios II.

Function
REQ-014 SHALL pass each in_port bit through a 2-flop synchronizer (s1, s2) before any other use.
REQ-015 SHALL keep per channel a debounced bit db and a CNT_W-bit counter cnt.
REQ-016 SHALL, each cycle where s2 == db, clear cnt to 0.
REQ-017 SHALL, each cycle where s2 != db and cnt < Peff-1, increment cnt; Peff = max(PERIOD,1).
REQ-018 SHALL, when s2 != db and cnt >= Peff-1, load db <= s2 and clear cnt; db changes on the Peff-th consecutive differing cycle.
REQ-019 SHALL give in_port-to-db latency of 2+Peff cycles for a clean step; any glitch shorter than Peff cycles at s2 SHALL leave db unchanged.
REQ-020 SHALL define registers: addr 0 DATA (RO, db), addr 1 MASK (RW, NCH bits), addr 2 EDGE (RW1C, NCH bits), addr 3 PERIOD (RW, CNT_W bits).
REQ-021 SHALL perform a write when chipselect && write; writes to addr 0 are ignored; unused writedata bits are ignored.
REQ-022 SHALL set EDGE[i] in the cycle db[i] changes from IDLE_LEVEL to !IDLE_LEVEL (press); releases SHALL NOT set EDGE.
REQ-023 SHALL clear EDGE[i] on a write to addr 2 with writedata[i]=1; a set and a clear of the same bit in the same cycle SHALL leave the bit set.
REQ-024 SHALL update readdata every clock with the register selected by address, zero-extended to 32 bits; reads SHALL have no side effects; 1-cycle latency.
REQ-025 SHALL drive irq = OR over i of (EDGE[i] & MASK[i]), combinationally from registered state.
REQ-026 SHALL apply a new PERIOD from the cycle after the write; channels whose cnt already >= new Peff-1 SHALL update db on the next differing cycle.
REQ-027 SHALL treat channels independently; simultaneous presses on several channels SHALL set all corresponding EDGE bits in the same cycle.

Reset
REQ-028 SHALL on reset_n low asynchronously set s1, s2, db to IDLE_LEVEL per bit, cnt to 0, MASK to 0, EDGE to 0, PERIOD to DEFAULT_PERIOD, readdata to 0; irq is then 0.
REQ-029 SHALL, when reset asserts mid-debounce, discard the partial count and generate no EDGE event after release of reset for inputs at IDLE_LEVEL.

Verification
REQ-030 SHALL cover: reset, in_port=3'b111 held -> readdata 0, irq 0, DATA reads 3'b111, EDGE reads 0 indefinitely.
REQ-031 SHALL cover: PERIOD=4, in_port[0] 1->0 held -> db[0]=0 exactly 6 cycles after step, EDGE=3'b001, DATA=3'b110.
REQ-032 SHALL cover: PERIOD=4, in_port[1] low for 3 cycles then high -> DATA stays 3'b111, EDGE stays 0.
REQ-033 SHALL cover: MASK=3'b010, press ch1 -> irq=1; write EDGE=3'b010 -> irq=0 next cycle; press ch2 -> EDGE=3'b100, irq stays 0.
REQ-034 SHALL cover: EDGE set event coincident with W1C write of same bit -> bit reads 1 afterward; PERIOD=0 write -> debounce acts as Peff=1 (db follows s2 one cycle later).
REQ-035 SHALL cover: reset_n pulsed low while cnt[0]=3 -> cnt 0, db 3'b111, PERIOD=50000, no EDGE after reset release.
